// File: rtl/slink_serdes_bringup_ctrl.sv
// Serial-link SerDes bring-up sequencer: clock request, lane enable, timed lane
// reset, receiver alignment, link up / clock idle, with a sticky wait timeout.
module slink_serdes_bringup_ctrl #(
   parameter int NUM_LANES   = 4,
   parameter int TIMEOUT_CYC = 1024,
   parameter int RESET_HOLD  = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 en,
   input  logic                 idle_req,
   input  logic [NUM_LANES-1:0] active_lanes,
   output logic                 phy_clk_enable,
   output logic                 phy_clk_idle,
   input  logic                 phy_clk_ready,
   output logic [NUM_LANES-1:0] phy_tx_enable,
   output logic [NUM_LANES-1:0] phy_tx_reset,
   output logic [NUM_LANES-1:0] phy_rx_enable,
   output logic [NUM_LANES-1:0] phy_rx_reset,
   output logic [NUM_LANES-1:0] phy_rx_align,
   input  logic [NUM_LANES-1:0] phy_tx_ready,
   input  logic [NUM_LANES-1:0] phy_rx_ready,
   input  logic [NUM_LANES-1:0] phy_rx_locked,
   output logic                 link_up,
   output logic                 timeout_err,
   output logic [2:0]           state
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam int SW = 3 * NUM_LANES + 1;

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_CLK_WAIT = 3'd1,
      ST_LANE_EN  = 3'd2,
      ST_LANE_RST = 3'd3,
      ST_ALIGN    = 3'd4,
      ST_UP       = 3'd5,
      ST_IDLE     = 3'd6,
      ST_ERR      = 3'd7
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_LANES-1:0] m_q, m_d;
   logic [CW-1:0]        wait_cnt_q, wait_cnt_d;
   logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
   logic                 timeout_err_q, timeout_err_d;
   logic [SW-1:0]        sync_meta_q, sync_meta_d, sync_q, sync_d;

   logic                 clk_en_q, clk_en_d, clk_idle_q, clk_idle_d, link_up_q, link_up_d;
   logic [NUM_LANES-1:0] tx_en_q, tx_en_d, rx_en_q, rx_en_d;
   logic [NUM_LANES-1:0] tx_rst_q, tx_rst_d, rx_rst_q, rx_rst_d, align_q, align_d;

   logic                 clk_ready_s;
   logic [NUM_LANES-1:0] tx_ready_s, rx_ready_s, rx_locked_s, lanes_ready_s;
   logic [CW-1:0]        wait_inc_s;
   logic                 wait_state_s;

   assign clk_ready_s   = sync_q[SW-1];
   assign tx_ready_s    = sync_q[3*NUM_LANES-1:2*NUM_LANES];
   assign rx_ready_s    = sync_q[2*NUM_LANES-1:NUM_LANES];
   assign rx_locked_s   = sync_q[NUM_LANES-1:0];
   assign lanes_ready_s = tx_ready_s & rx_ready_s;
   assign wait_inc_s    = wait_cnt_q + CW'(1);
   assign wait_state_s  = (state_q == ST_CLK_WAIT) || (state_q == ST_LANE_EN) ||
                          (state_q == ST_ALIGN);

   // Next-state, counter, synchronizer and registered-output decode
   always_comb begin
      state_d       = state_q;
      m_d           = m_q;
      wait_cnt_d    = '0;
      hold_cnt_d    = '0;
      sync_meta_d   = {phy_clk_ready, phy_tx_ready, phy_rx_ready, phy_rx_locked};
      sync_d        = sync_meta_q;

      case (state_q)
         ST_OFF: begin
            if (en && (active_lanes != '0)) begin
               state_d = ST_CLK_WAIT;
               m_d     = active_lanes;
            end else begin
               state_d = ST_OFF;
            end
         end
         ST_CLK_WAIT: begin
            if (clk_ready_s) state_d = ST_LANE_EN;
            else             state_d = ST_CLK_WAIT;
         end
         ST_LANE_EN: begin
            if ((lanes_ready_s & m_q) == m_q) state_d = ST_LANE_RST;
            else                              state_d = ST_LANE_EN;
         end
         ST_LANE_RST: begin
            if (hold_cnt_q == HW'(RESET_HOLD - 1)) begin
               state_d = ST_ALIGN;
            end else begin
               state_d    = ST_LANE_RST;
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end
         ST_ALIGN: begin
            if ((rx_locked_s & m_q) == m_q) state_d = ST_UP;
            else                            state_d = ST_ALIGN;
         end
         ST_UP: begin
            if ((rx_locked_s & m_q) != m_q) state_d = ST_ALIGN;
            else if (idle_req)              state_d = ST_IDLE;
            else                            state_d = ST_UP;
         end
         ST_IDLE: begin
            if (!idle_req) state_d = ST_ALIGN;
            else           state_d = ST_IDLE;
         end
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_OFF;
      endcase

      // Timeout outranks the normal move; the counter restarts on any state change
      if (wait_state_s) begin
         if (wait_inc_s == CW'(TIMEOUT_CYC)) begin
            state_d    = ST_ERR;
            wait_cnt_d = '0;
         end else if (state_d == state_q) begin
            wait_cnt_d = wait_inc_s;
         end else begin
            wait_cnt_d = '0;
         end
      end else begin
         wait_cnt_d = '0;
      end

      if (!en) begin
         state_d    = ST_OFF;
         wait_cnt_d = '0;
         hold_cnt_d = '0;
      end else begin
         state_d = state_d;
      end

      if (state_d == ST_OFF)      timeout_err_d = 1'b0;
      else if (state_d == ST_ERR) timeout_err_d = 1'b1;
      else                        timeout_err_d = timeout_err_q;

      clk_en_d   = 1'b0;
      clk_idle_d = 1'b0;
      link_up_d  = 1'b0;
      tx_en_d    = '0;
      rx_en_d    = '0;
      tx_rst_d   = '1;
      rx_rst_d   = '1;
      align_d    = '0;
      case (state_d)
         ST_CLK_WAIT: clk_en_d = 1'b1;
         ST_LANE_EN, ST_LANE_RST: begin
            clk_en_d = 1'b1;
            tx_en_d  = m_d;
            rx_en_d  = m_d;
         end
         ST_ALIGN, ST_UP, ST_IDLE: begin
            clk_en_d   = 1'b1;
            tx_en_d    = m_d;
            rx_en_d    = m_d;
            tx_rst_d   = ~m_d;
            rx_rst_d   = ~m_d;
            align_d    = (state_d == ST_ALIGN) ? m_d : '0;
            link_up_d  = (state_d == ST_UP);
            clk_idle_d = (state_d == ST_IDLE);
         end
         default: clk_en_d = 1'b0;
      endcase
   end

   // State, counters, synchronizers and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_OFF;
         m_q           <= '0;
         wait_cnt_q    <= '0;
         hold_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
         sync_meta_q   <= '0;
         sync_q        <= '0;
         clk_en_q      <= 1'b0;
         clk_idle_q    <= 1'b0;
         link_up_q     <= 1'b0;
         tx_en_q       <= '0;
         rx_en_q       <= '0;
         tx_rst_q      <= '1;
         rx_rst_q      <= '1;
         align_q       <= '0;
      end else begin
         state_q       <= state_d;
         m_q           <= m_d;
         wait_cnt_q    <= wait_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         timeout_err_q <= timeout_err_d;
         sync_meta_q   <= sync_meta_d;
         sync_q        <= sync_d;
         clk_en_q      <= clk_en_d;
         clk_idle_q    <= clk_idle_d;
         link_up_q     <= link_up_d;
         tx_en_q       <= tx_en_d;
         rx_en_q       <= rx_en_d;
         tx_rst_q      <= tx_rst_d;
         rx_rst_q      <= rx_rst_d;
         align_q       <= align_d;
      end
   end

   assign state          = state_q;
   assign timeout_err    = timeout_err_q;
   assign link_up        = link_up_q;
   assign phy_clk_enable = clk_en_q;
   assign phy_clk_idle   = clk_idle_q;
   assign phy_tx_enable  = tx_en_q;
   assign phy_rx_enable  = rx_en_q;
   assign phy_tx_reset   = tx_rst_q;
   assign phy_rx_reset   = rx_rst_q;
   assign phy_rx_align   = align_q;

endmodule

// File: doc/slink_serdes_bringup_ctrl.md
SLINK_SERDES_BRINGUP_CTRL -- requirements
Module: slink_serdes_bringup_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_LANES, default 4, lanes controlled; TIMEOUT_CYC, default 1024, max cycles in any wait state; RESET_HOLD, default 8, lane reset hold cycles.
REQ-002 clk  in  1  single block clock; all logic on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 en  in  1  link bring-up request; 0 powers the PHY down.
REQ-005 idle_req  in  1  request bit clock idle while link is up.
REQ-006 active_lanes  in  NUM_LANES  lane mask; latched on OFF exit.
REQ-007 phy_clk_enable, phy_clk_idle  out  1 each  PHY clock enable and idle.
REQ-008 phy_clk_ready  in  1  PHY clock ready.
REQ-009 phy_tx_enable, phy_tx_reset, phy_rx_enable, phy_rx_reset, phy_rx_align  out  NUM_LANES each  per-lane PHY controls; resets active-high.
REQ-010 phy_tx_ready, phy_rx_ready, phy_rx_locked  in  NUM_LANES each  per-lane PHY status; asynchronous to clk.
REQ-011 link_up  out  1  all masked lanes locked.
REQ-012 timeout_err  out  1  sticky wait-state timeout flag.
REQ-013 state  out  3  current state encoding.

Function
REQ-014 Every PHY status input SHALL pass through a 2-flop synchronizer before use; "_s" below means the synchronized value (2-cycle latency).
REQ-015 States and encodings SHALL be OFF=0, CLK_WAIT=1, LANE_EN=2, LANE_RST=3, ALIGN=4, UP=5, IDLE=6, ERR=7; outputs are registered from the state and the latched mask M.
REQ-016 OFF: clk_enable=0, all enables/align=0, all tx/rx resets=1, link_up=0; en=1 with active_lanes!=0 latches M=active_lanes and moves to CLK_WAIT; en=1 with active_lanes==0 stays in OFF.
REQ-017 CLK_WAIT: phy_clk_enable=1; phy_clk_ready_s=1 moves to LANE_EN.
REQ-018 LANE_EN: phy_tx_enable=phy_rx_enable=M, resets held; all bits of M set in (phy_tx_ready_s & phy_rx_ready_s) move to LANE_RST.
REQ-019 LANE_RST: resets held exactly RESET_HOLD cycles, then phy_tx_reset/phy_rx_reset deassert for M lanes on entry to ALIGN; unmasked lanes stay in reset, disabled.
REQ-020 ALIGN: phy_rx_align=M; (phy_rx_locked_s & M)==M moves to UP, and phy_rx_align drops to 0 on that transition.
REQ-021 UP: link_up=1; any M lane losing phy_rx_locked_s moves to ALIGN (link_up=0 next cycle); idle_req=1 moves to IDLE.
REQ-022 IDLE: phy_clk_idle=1, link_up=0, lanes stay enabled and out of reset; idle_req=0 moves to ALIGN.
REQ-023 Wait counter SHALL clear on every state change and count only in CLK_WAIT, LANE_EN, ALIGN; reaching TIMEOUT_CYC moves to ERR and sets timeout_err.
REQ-024 ERR: outputs as in OFF; timeout_err stays 1 until next OFF entry; en=0 moves to OFF.
REQ-025 Priority per cycle SHALL be: en=0 (to OFF from any state) > timeout > normal transition.
REQ-026 Changes of active_lanes outside OFF SHALL be ignored.
REQ-027 Timeout counter SHALL be wide enough to hold TIMEOUT_CYC without wrap.

Reset
REQ-028 reset_n=0 SHALL immediately force state=OFF, M=0, counters=0, synchronizers=0, timeout_err=0, link_up=0, phy_clk_enable=phy_clk_idle=0, enables/align=0, phy_tx_reset=phy_rx_reset=all ones.
REQ-029 reset_n assertion mid-sequence SHALL abort without intermediate glitches; first transition out of OFF occurs no earlier than the first clk edge after release.

Verification
REQ-030 Nominal: en=1, mask=4'hF, ready at 20 cycles, all ready at 50, lock at 100 -> states 1,2,3,4,5 in order; resets low exactly 8 cycles after LANE_RST entry; link_up=1.
REQ-031 Partial mask: mask=4'b0101 -> lanes 1,3 enable=0, reset=1 throughout; lanes 1,3 never locking does not block UP.
REQ-032 Timeout: phy_clk_ready held 0 -> ERR after 1024 cycles in CLK_WAIT, timeout_err=1, all resets=1; en=0 -> OFF and timeout_err=0.
REQ-033 Lock loss: in UP drop phy_rx_locked[2] -> state=ALIGN, link_up=0, phy_rx_align=M; relock -> UP.
REQ-034 Idle and abort: idle_req=1 in UP -> IDLE, phy_clk_idle=1; en=0 in same cycle as idle_req=0 -> OFF, not ALIGN.
REQ-035 Async reset: reset_n=0 in LANE_RST -> all outputs at REQ-028 values within the same cycle, state=0.
